// File: rtl/ibex_mem_arb_pkg.sv
// Shared types for the ibex instruction/data memory port arbiter.
// Optional perf counters in the top are enabled by IBEX_MEM_ARB_PERF_EN.
package ibex_mem_arb_pkg;

    typedef enum logic {
        ARB_SRC_DATA  = 1'b0,
        ARB_SRC_INSTR = 1'b1
    } arb_src_e;

    typedef enum logic {
        ARB_ST_ARB,
        ARB_ST_HOLD
    } arb_state_e;

    typedef struct packed {
        arb_src_e    src;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } arb_req_t;

endpackage

// File: rtl/ibex_mem_arb_id_fifo.sv
// One-bit-wide ID FIFO recording which master owns each outstanding access.
// A push is accepted while full when a pop happens in the same cycle.
module ibex_mem_arb_id_fifo #(
    parameter int unsigned Depth = 2,
    localparam int unsigned CntW = $clog2(Depth + 1),
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic            data_i,
    input  logic            pop_i,
    output logic            head_o,
    output logic [CntW-1:0] count_o,
    output logic            full_o,
    output logic            empty_o
);

    logic [Depth-1:0] mem_q;
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o  = (count_o == CntW'(Depth));
    assign empty_o = (count_o == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_o  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_o <= count_o + CntW'(1);
            end else if (do_pop && !do_push) begin
                count_o <= count_o - CntW'(1);
            end
        end
    end

endmodule

// File: rtl/ibex_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and load/store.
// Define IBEX_MEM_ARB_PERF_EN to add per-master stall cycle counters.
module ibex_mem_arbiter
    import ibex_mem_arb_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2,
    parameter logic        InstrFirst     = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    input  logic [31:0] instr_addr_i,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic        spurious_rsp_o
`ifdef IBEX_MEM_ARB_PERF_EN
    ,
    output logic [31:0] perf_instr_stall_o,
    output logic [31:0] perf_data_stall_o
`endif
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    arb_state_e      state_q, state_d;
    arb_src_e        last_q, last_d;
    arb_req_t        hold_q, hold_d;
    arb_req_t        instr_a, data_a, win;
    logic            issue, push, pop, can_issue;
    logic            head, full, empty;
    logic [CntW-1:0] count;

    assign instr_a = '{src: ARB_SRC_INSTR, we: 1'b0, be: 4'hF,
                       addr: instr_addr_i, wdata: '0};
    assign data_a  = '{src: ARB_SRC_DATA, we: data_we_i, be: data_be_i,
                       addr: data_addr_i, wdata: data_wdata_i};

    assign pop       = mem_rvalid_i && !empty && !rst_i;
    assign can_issue = !full || pop;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        hold_d  = hold_q;
        win     = '0;
        issue   = 1'b0;
        unique case (state_q)
            ARB_ST_ARB: begin
                if (can_issue && (instr_req_i || data_req_i)) begin
                    issue = 1'b1;
                    unique case (1'b1)
                        instr_req_i && data_req_i:
                            win = (last_q == ARB_SRC_INSTR) ? data_a : instr_a;
                        instr_req_i && !data_req_i: win = instr_a;
                        data_req_i && !instr_req_i: win = data_a;
                    endcase
                    if (mem_gnt_i) begin
                        last_d = win.src;
                    end else begin
                        hold_d  = win;
                        state_d = ARB_ST_HOLD;
                    end
                end
            end
            ARB_ST_HOLD: begin
                issue = 1'b1;
                win   = hold_q;
                if (mem_gnt_i) begin
                    last_d  = win.src;
                    state_d = ARB_ST_ARB;
                end
            end
            default: state_d = ARB_ST_ARB;
        endcase
        // Outputs stay quiet while reset is held, whatever the masters do.
        if (rst_i) begin
            issue = 1'b0;
            win   = '0;
        end
    end

    assign push = issue && mem_gnt_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ARB_ST_ARB;
            last_q  <= InstrFirst ? ARB_SRC_DATA : ARB_SRC_INSTR;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    ibex_mem_arb_id_fifo #(
        .Depth (MaxOutstanding)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (logic'(win.src)),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    assign mem_req_o   = issue;
    assign mem_we_o    = win.we;
    assign mem_be_o    = win.be;
    assign mem_addr_o  = win.addr;
    assign mem_wdata_o = win.wdata;

    assign instr_gnt_o = push && (win.src == ARB_SRC_INSTR);
    assign data_gnt_o  = push && (win.src == ARB_SRC_DATA);

    assign instr_rvalid_o = pop && (head == 1'b1);
    assign data_rvalid_o  = pop && (head == 1'b0);
    assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
    assign data_rdata_o   = data_rvalid_o ? mem_rdata_i : '0;
    assign instr_err_o    = instr_rvalid_o && mem_err_i;
    assign data_err_o     = data_rvalid_o && mem_err_i;
    assign spurious_rsp_o = mem_rvalid_i && empty && !rst_i;

    hold_req_kept: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == ARB_ST_HOLD) |->
        ((hold_q.src == ARB_SRC_INSTR) ? instr_req_i : data_req_i));

    count_in_range: assert property (@(posedge clk_i) disable iff (rst_i)
        count <= CntW'(MaxOutstanding));

`ifdef IBEX_MEM_ARB_PERF_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_instr_stall_o <= '0;
            perf_data_stall_o  <= '0;
        end else begin
            if (instr_req_i && !instr_gnt_o && (perf_instr_stall_o != '1)) begin
                perf_instr_stall_o <= perf_instr_stall_o + 32'd1;
            end
            if (data_req_i && !data_gnt_o && (perf_data_stall_o != '1)) begin
                perf_data_stall_o <= perf_data_stall_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Randomized bench for ibex_mem_arbiter against a queue-based reference.
// Directed scenarios first, then random masters and memory behaviour.
module tb_ibex_mem_arbiter;

    localparam int  MAX         = 2;
    localparam bit  INSTR_FIRST = 1'b0;

    logic        clk_i = 1'b0;
    logic        rst_i, instr_req_i, data_req_i, data_we_i;
    logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
    logic [31:0] instr_addr_i, data_addr_i, data_wdata_i, mem_rdata_i;
    logic [3:0]  data_be_i;
    logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic        mem_req_o, mem_we_o, spurious_rsp_o;
    logic [3:0]  mem_be_o;
    logic [31:0] instr_rdata_o, data_rdata_o;
    logic [31:0] mem_addr_o, mem_wdata_o;

    ibex_mem_arbiter #(
        .MaxOutstanding (MAX),
        .InstrFirst     (INSTR_FIRST)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .instr_req_i    (instr_req_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_addr_i   (instr_addr_i),
        .instr_rdata_o  (instr_rdata_o),
        .instr_err_o    (instr_err_o),
        .data_req_i     (data_req_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_rdata_o   (data_rdata_o),
        .data_err_o     (data_err_o),
        .mem_req_o      (mem_req_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (mem_rdata_i),
        .mem_err_i      (mem_err_i),
        .spurious_rsp_o (spurious_rsp_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;

    // Master-side request state, held until granted.
    bit          i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_be;

    // Reference model: queue of outstanding owners (1 = instr).
    bit q[$];
    bit hold, hold_src, last;

    bit          e_req, e_src, e_ig, e_dg, e_iv, e_dv, e_sp, e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wd;
    bit          obs_req, obs_ig, obs_dg, obs_sp;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit gnt, input bit rv,
                        input logic [31:0] rd, input bit er);
        bit pop_ok;
        rst_i        = rst;
        mem_gnt_i    = gnt;
        mem_rvalid_i = rv;
        mem_rdata_i  = rd;
        mem_err_i    = er;
        instr_req_i  = i_req;
        instr_addr_i = i_addr;
        data_req_i   = d_req;
        data_we_i    = d_we;
        data_be_i    = d_be;
        data_addr_i  = d_addr;
        data_wdata_i = d_wdata;
        #1;
        pop_ok = rv && (q.size() != 0);
        {e_req, e_src, e_iv, e_dv, e_sp} = '0;
        if (!rst) begin
            if (pop_ok) begin
                e_iv = q[0];
                e_dv = !q[0];
            end
            e_sp = rv && (q.size() == 0);
            if (hold) begin
                e_req = 1'b1;
                e_src = hold_src;
            end else if ((i_req || d_req) && (q.size() < MAX || pop_ok)) begin
                e_req = 1'b1;
                e_src = (i_req && d_req) ? !last : i_req;
            end
        end
        e_we = 1'b0; e_be = '0; e_addr = '0; e_wd = '0;
        if (e_req && e_src) begin
            e_be = 4'hF; e_addr = i_addr;
        end else if (e_req) begin
            e_we = d_we; e_be = d_be; e_addr = d_addr; e_wd = d_wdata;
        end
        e_ig = e_req && gnt && e_src;
        e_dg = e_req && gnt && !e_src;
        check("mem_req", 64'(mem_req_o), 64'(e_req));
        check("mem_attr", {mem_we_o, mem_be_o, mem_addr_o},
              {e_we, e_be, e_addr});
        check("mem_wdata", 64'(mem_wdata_o), 64'(e_wd));
        check("gnt", {instr_gnt_o, data_gnt_o}, {e_ig, e_dg});
        check("rvalid", {instr_rvalid_o, data_rvalid_o, spurious_rsp_o},
              {e_iv, e_dv, e_sp});
        check("instr_rsp", {instr_err_o, instr_rdata_o},
              {e_iv && er, e_iv ? rd : 32'h0});
        check("data_rsp", {data_err_o, data_rdata_o},
              {e_dv && er, e_dv ? rd : 32'h0});
        obs_req = mem_req_o;
        obs_ig  = instr_gnt_o;
        obs_dg  = data_gnt_o;
        obs_sp  = spurious_rsp_o;
        @(posedge clk_i);
        if (rst) begin
            q.delete();
            hold = 1'b0;
            last = !INSTR_FIRST;
        end else begin
            if (pop_ok) void'(q.pop_front());
            if (e_req && gnt) begin
                q.push_back(e_src);
                last = e_src;
                hold = 1'b0;
            end else if (e_req) begin
                hold     = 1'b1;
                hold_src = e_src;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h1234, 1'b1);
    endtask

    task automatic masters_next();
        if (e_ig || !i_req) begin
            i_req  = ($urandom_range(0, 2) != 0);
            i_addr = $urandom & 32'hFFFF_FFFC;
        end
        if (e_dg || !d_req) begin
            d_req   = ($urandom_range(0, 2) != 0);
            d_we    = 1'($urandom);
            d_be    = 4'($urandom);
            d_addr  = $urandom;
            d_wdata = $urandom;
        end
    endtask

    initial begin
        i_req = 0; d_req = 0; d_we = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0;
        hold = 0; hold_src = 0; last = !INSTR_FIRST;
        do_reset();

        // Single fetch, then its response.
        i_req = 1; i_addr = 32'h100;
        step(0, 1, 0, 32'h0, 0);
        check("fetch_gnt", 64'(obs_ig), 64'(1));
        i_req = 0;
        step(0, 0, 1, 32'hDEADBEEF, 0);

        // Both masters contend: D,I,D,I.
        do_reset();
        i_req = 1; i_addr = 32'h200;
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h1000;
        for (int k = 0; k < 6; k++) begin
            step(0, 1, q.size() != 0, $urandom, 0);
            check("alternate", 64'(obs_dg), 64'(k % 2 == 0));
        end
        i_req = 0; d_req = 0;

        // Data write stalled by memory; instr waits behind it.
        do_reset();
        d_req = 1; d_we = 1; d_be = 4'h3; d_addr = 32'h2000;
        d_wdata = 32'hCAFE0001;
        i_req = 1; i_addr = 32'h300;
        repeat (3) step(0, 0, 0, 32'h0, 0);
        step(0, 1, 0, 32'h0, 0);
        check("hold_data_gnt", 64'(obs_dg), 64'(1));
        d_req = 0;
        step(0, 1, 0, 32'h0, 0);
        check("hold_instr_next", 64'(obs_ig), 64'(1));
        i_req = 0;

        // Outstanding limit and same-cycle pop/push.
        do_reset();
        i_req = 1; d_req = 1; d_we = 0; d_addr = 32'h44;
        step(0, 1, 0, 32'h0, 0);
        step(0, 1, 0, 32'h0, 0);
        step(0, 1, 0, 32'h0, 0);
        check("full_no_req", 64'(obs_req), 64'(0));
        step(0, 1, 1, 32'h55, 0);
        check("full_pop_gnt", 64'(obs_ig | obs_dg), 64'(1));
        i_req = 0; d_req = 0;

        // Stray response with nothing outstanding.
        do_reset();
        step(0, 0, 1, 32'h77, 1);
        check("spurious", 64'(obs_sp), 64'(1));

        // Reset with transactions in flight.
        do_reset();
        i_req = 1; d_req = 1;
        step(0, 1, 0, 32'h0, 0);
        step(0, 1, 0, 32'h0, 0);
        i_req = 0; d_req = 0;
        step(1, 0, 0, 32'h0, 0);
        step(0, 0, 1, 32'h88, 0);
        check("post_rst_spur0", 64'(obs_sp), 64'(1));
        step(0, 0, 1, 32'h99, 0);
        check("post_rst_spur1", 64'(obs_sp), 64'(1));
        i_req = 1; i_addr = 32'h400;
        step(0, 1, 0, 32'h0, 0);
        check("post_rst_gnt", 64'(obs_ig), 64'(1));
        i_req = 0;

        // Random traffic.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 1) == 1, $urandom,
                 $urandom_range(0, 7) == 0);
            masters_next();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
